// File: rtl/nsa_pkg.sv
// -----------------------------------------------------------------------------
// nsa_pkg
// Shared definitions for the nibble-serial adder sequencer.
//   state_t   : controller state encoding (IDLE, RUN)
//   NIBBLE_W  : width of the time-shared adder slice
//   MIN_WIDTH : smallest legal operand width
//   width_ok(): legality check for the operand width parameter
// Optional feature macro used by the design: NSA_SUB_EN (A-B support).
// -----------------------------------------------------------------------------
package nsa_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NIBBLE_W  = 4;
    localparam int MIN_WIDTH = 4;

    // Operand width must be a whole number of nibbles and at least one nibble.
    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && ((w % NIBBLE_W) == 0);
    endfunction

endpackage

// File: rtl/fa4_cin.sv
// -----------------------------------------------------------------------------
// fa4_cin / basys3_fa
// Combinational 4-bit ripple-carry adder with carry in and carry out, built
// from four basys3_fa full-adder cells.
// basys3_fa ports:
//   a, b, cin  in  1   addend bits and carry in
//   s          out 1   sum bit
//   cout       out 1   carry out
// fa4_cin ports:
//   a, b       in  4   nibble operands
//   cin        in  1   carry into bit 0
//   sum        out 4   nibble result
//   cout       out 1   carry out of bit 3
// -----------------------------------------------------------------------------
module basys3_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module fa4_cin
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    assign c[0] = cin;
    assign cout = c[NIBBLE_W];

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        basys3_fa u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl
// WIDTH-bit addition performed nibble by nibble (LSB first) through a single
// 4-bit ripple adder, with the carry registered between nibbles. A result
// takes WIDTH/4 cycles after START is accepted.
// Optional feature: define NSA_SUB_EN to add the SUB port (A-B via inverted B
// and an initial carry of 1; SUM[WIDTH]=1 then means "no borrow").
// Ports:
//   CLK      in   1        rising-edge clock
//   RESET_N  in   1        asynchronous active-low reset
//   START    in   1        request, sampled only while BUSY=0
//   A, B     in   WIDTH    operands, captured on the accepting edge
//   SUB      in   1        (NSA_SUB_EN only) 1 = compute A-B
//   BUSY     out  1        high while a sequence runs
//   DONE     out  1        one-cycle pulse when SUM takes a new result
//   SUM      out  WIDTH+1  result, MSB = final carry out
// -----------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef NSA_SUB_EN
    input  logic             SUB,
`endif
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH:0]   SUM
);

    import nsa_pkg::*;

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t state, state_nxt;
    logic   load, step, last;
    logic   sub_req;

    logic [IDX_W-1:0]    idx_p0;
    logic                carry_p0;
    logic [WIDTH-1:0]    a_p0, b_p0, acc_p0, acc_nxt;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic [WIDTH:0]      sum_p1;
    logic                vld_p1;

`ifdef NSA_SUB_EN
    assign sub_req = SUB;
`else
    assign sub_req = 1'b0;
`endif

    assign last = (idx_p0 == IDX_W'(NIBBLES - 1));

    // ---- FSM ----
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p0: operand shift registers feeding the shared nibble adder ----
    // Operands shift right one nibble per RUN edge so the adder always sees
    // the current nibble in the low bits; results shift in from the top so
    // that after NIBBLES edges nibble 0 sits at the bottom of the accumulator.
    fa4_cin u_fa4 (
        .a    (a_p0[NIBBLE_W-1:0]),
        .b    (b_p0[NIBBLE_W-1:0]),
        .cin  (carry_p0),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    assign acc_nxt = (WIDTH'(nib_sum) << (WIDTH - NIBBLE_W)) | (acc_p0 >> NIBBLE_W);

    always_ff @(posedge CLK) begin
        if (load) begin
            a_p0 <= A;
            b_p0 <= sub_req ? ~B : B;
        end else if (step) begin
            a_p0   <= a_p0 >> NIBBLE_W;
            b_p0   <= b_p0 >> NIBBLE_W;
            acc_p0 <= acc_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            idx_p0   <= '0;
            carry_p0 <= 1'b0;
        end else if (load) begin
            idx_p0   <= '0;
            carry_p0 <= sub_req;
        end else if (step) begin
            idx_p0   <= last ? '0 : idx_p0 + IDX_W'(1);
            carry_p0 <= nib_cout;
        end
    end

    // ---- stage p1: result register and completion pulse ----
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sum_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (step && last) begin
                sum_p1 <= {nib_cout, acc_nxt};
                vld_p1 <= 1'b1;
            end
        end
    end

    assign BUSY = (state == RUN);
    assign DONE = vld_p1;
    assign SUM  = sum_p1;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;
`ifdef NSA_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [WIDTH-1:0]  a, b;
`ifdef NSA_SUB_EN
    logic              sub;
`endif
    logic              busy, done;
    logic [WIDTH:0]    sum;

    int total = 0;
    int bad   = 0;
    logic [WIDTH:0] exp_prev;   // value the SUM register should be holding

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .START   (start),
        .A       (a),
        .B       (b),
`ifdef NSA_SUB_EN
        .SUB     (sub),
`endif
        .BUSY    (busy),
        .DONE    (done),
        .SUM     (sum)
    );

    // Reference: plain integer arithmetic. Subtraction gives the difference
    // modulo 2^WIDTH with the top bit set when no borrow occurs (x >= y).
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input bit s);
        logic [WIDTH:0] r;
        if (s) begin
            r[WIDTH-1:0] = x - y;
            r[WIDTH]     = (x >= y);
        end else begin
            r = {1'b0, x} + {1'b0, y};
        end
        return r;
    endfunction

    // Stimulus only: present a request for one cycle, then scramble operands
    // so any late sampling of A/B/SUB would corrupt the result.
    task automatic drive_start(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input bit s, input bit now);
        if (!now) @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
`ifdef NSA_SUB_EN
        sub = s;
`endif
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
`ifdef NSA_SUB_EN
        sub = 1'($urandom);
`endif
    endtask

    // Observation only: count cycles from the accepting edge to DONE (bounded).
    task automatic wait_done(output int cyc, output bit busy_ok, output bit hold_ok);
        busy_ok = (busy === 1'b1);
        hold_ok = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (sum !== exp_prev) hold_ok = 1'b0;
        end while (cyc < 20);
    endtask

    task automatic test_reset_init();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
`ifdef NSA_SUB_EN
        sub = 1'b0;
`endif
        exp_prev = '0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL init_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL init_done: got %b want 0", done); end
        total++; if (sum !== '0) begin bad++; $display("FAIL init_sum: got %h want 0", sum); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input bit s, input string nm);
        logic [WIDTH:0] e;
        int cyc;
        bit bo, ho;
        e = model(x, y, s);
        drive_start(x, y, s, 1'b0);
        wait_done(cyc, bo, ho);
        total++; if (cyc !== NIBBLES) begin bad++; $display("FAIL %s_latency: got %0d want %0d", nm, cyc, NIBBLES); end
        total++; if (!bo) begin bad++; $display("FAIL %s_busy_run: busy dropped early, want 1", nm); end
        total++; if (!ho) begin bad++; $display("FAIL %s_sum_hold: sum changed before done, want %h", nm, exp_prev); end
        total++; if (sum !== e) begin bad++; $display("FAIL %s_sum: got %h want %h (a=%h b=%h sub=%0d)", nm, sum, e, x, y, s); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_end: got %b want 0", nm, busy); end
        exp_prev = e;
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse: got %b want 0", nm, done); end
    endtask

    task automatic test_directed();
        test_add(16'h00FF, 16'h0001, 1'b0, "add_ff_1");
        total++; if (sum !== 17'h00100) begin bad++; $display("FAIL add_ff_1_const: got %h want 00100", sum); end
        test_add(16'hFFFF, 16'h0001, 1'b0, "add_ripple");
        total++; if (sum !== 17'h10000) begin bad++; $display("FAIL add_ripple_const: got %h want 10000", sum); end
    endtask

    task automatic test_reset_idle();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_idle_done: got %b want 0", done); end
        total++; if (sum !== '0) begin bad++; $display("FAIL rst_idle_sum: got %h want 0", sum); end
        exp_prev = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ignore_back_to_back();
        logic [WIDTH:0] e1;
        int cyc;
        bit bo, ho;
        e1 = model(16'h0F0F, 16'h0101, 1'b0);
        drive_start(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        @(negedge clk);                 // after t1
        start = 1'b1;                   // sampled at t2 while running
        a = 16'h1234;
        b = 16'h1111;
        @(negedge clk);                 // after t2
        start = 1'b0;
        @(negedge clk);                 // after t3
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy: got %b want 1", busy); end
        @(negedge clk);                 // after t4
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_done: got %b want 1", done); end
        total++; if (sum !== e1) begin bad++; $display("FAIL ign_sum: got %h want %h", sum, e1); end
        exp_prev = e1;
        drive_start(16'h0001, 16'h0002, 1'b0, 1'b1);   // in the DONE cycle
        wait_done(cyc, bo, ho);
        total++; if (!bo) begin bad++; $display("FAIL b2b_busy: busy not continuous, want 1"); end
        total++; if (cyc !== NIBBLES) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", cyc, NIBBLES); end
        total++; if (sum !== 17'h00003) begin bad++; $display("FAIL b2b_sum: got %h want 00003", sum); end
        exp_prev = 17'h00003;
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_abort();
        int dn;
        drive_start(16'h4321, 16'h1234, 1'b0, 1'b0);
        repeat (2) @(negedge clk);      // idx now 2
        #1 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (sum !== '0) begin bad++; $display("FAIL abort_sum: got %h want 0", sum); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done); end
        exp_prev = '0;
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dn); end
        test_add(16'h4321, 16'h1234, 1'b0, "after_abort");
    endtask

    task automatic test_sub();
`ifdef NSA_SUB_EN
        test_add(16'h0005, 16'h0007, 1'b1, "sub_borrow");
        total++; if (sum !== 17'h0FFFE) begin bad++; $display("FAIL sub_borrow_const: got %h want 0fffe", sum); end
        test_add(16'h0007, 16'h0005, 1'b1, "sub_noborrow");
        total++; if (sum !== 17'h10002) begin bad++; $display("FAIL sub_noborrow_const: got %h want 10002", sum); end
`endif
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] x, y;
        bit s;
        for (int i = 0; i < 24; i++) begin
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
            s = HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0;
            test_add(x, y, s, "rand");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset_init();
        test_directed();
        test_reset_idle();
        test_ignore_back_to_back();
        test_abort();
        test_sub();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
